// File: rtl/tdes_byte_stream_adapter.sv
// tdes_byte_stream_adapter
// Byte-stream wrapper around the triple DES core. Eight input bytes are
// packed into a 64-bit block, the core is started with a one-cycle enable,
// and its 64-bit result is drained as eight bytes over valid/ready.
// A wait timeout returns the adapter to LOAD and pulses err.

module tdes_byte_stream_adapter #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_byte,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_mode,
    output logic        des_enable,
    output logic        des_encr_decr,
    output logic [63:0] des_input_block,
    input  logic [63:0] des_output_block,
    input  logic        des_done,
    output logic [7:0]  out_byte,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy,
    output logic        err
);

    // Timeout counter width holds TIMEOUT_CYCLES; kept at 1 bit when disabled.
    localparam int TW = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam bit TO_EN_C = (TIMEOUT_CYCLES != 0);
    localparam logic [TW-1:0] TO_LAST_C = (TIMEOUT_CYCLES < 1) ? {TW{1'b0}} : TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t          state_r;
    state_t          state_s;
    logic [2:0]      byte_cnt_r;
    logic [TW-1:0]   to_cnt_r;
    logic [63:0]     in_shift_r;
    logic [63:0]     out_shift_r;
    logic            mode_r;
    logic            in_ready_r;
    logic            des_enable_r;
    logic            out_valid_r;
    logic            busy_r;
    logic            err_r;

    logic            accept_s;
    logic            handshake_s;
    logic            capture_s;
    logic            timeout_s;

    // Next-state decode and per-cycle event strobes.
    always_comb begin
        state_s     = state_r;
        accept_s    = 1'b0;
        handshake_s = 1'b0;
        capture_s   = 1'b0;
        timeout_s   = 1'b0;
        case (state_r)
            ST_LOAD: begin
                accept_s = in_valid;
                if (in_valid && (byte_cnt_r == 3'd7)) begin
                    state_s = ST_START;
                end else begin
                    state_s = ST_LOAD;
                end
            end
            ST_START: begin
                state_s = ST_WAIT;
            end
            ST_WAIT: begin
                // A done on the last timeout cycle still wins over the timeout.
                if (des_done) begin
                    capture_s = 1'b1;
                    state_s   = ST_DRAIN;
                end else if (TO_EN_C && (to_cnt_r == TO_LAST_C)) begin
                    timeout_s = 1'b1;
                    state_s   = ST_LOAD;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_DRAIN: begin
                handshake_s = out_ready;
                if (out_ready && (byte_cnt_r == 3'd7)) begin
                    state_s = ST_LOAD;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            default: begin
                state_s = ST_LOAD;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_LOAD;
        end else begin
            state_r <= state_s;
        end
    end

    // Shared byte counter: counts accepted input bytes, then drained output bytes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_cnt_r <= 3'd0;
        end else if (accept_s || handshake_s) begin
            byte_cnt_r <= byte_cnt_r + 3'd1;
        end else begin
            byte_cnt_r <= byte_cnt_r;
        end
    end

    // Wait-cycle counter: cleared while starting the core, runs only in WAIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt_r <= {TW{1'b0}};
        end else if (state_r == ST_START) begin
            to_cnt_r <= {TW{1'b0}};
        end else if (state_r == ST_WAIT) begin
            to_cnt_r <= to_cnt_r + TW'(1'b1);
        end else begin
            to_cnt_r <= to_cnt_r;
        end
    end

    // Input assembly: bytes enter at the LSB end; mode is taken with the first byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_shift_r <= 64'h0;
            mode_r     <= 1'b0;
        end else if (accept_s) begin
            in_shift_r <= {in_shift_r[55:0], in_byte};
            mode_r     <= (byte_cnt_r == 3'd0) ? in_mode : mode_r;
        end else begin
            in_shift_r <= in_shift_r;
            mode_r     <= mode_r;
        end
    end

    // Output shift register: loads the core result, shifts out MSB byte first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_shift_r <= 64'h0;
        end else if (capture_s) begin
            out_shift_r <= des_output_block;
        end else if (handshake_s) begin
            out_shift_r <= {out_shift_r[55:0], 8'h00};
        end else begin
            out_shift_r <= out_shift_r;
        end
    end

    // Status and strobe outputs registered from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready_r   <= 1'b1;
            des_enable_r <= 1'b0;
            out_valid_r  <= 1'b0;
            busy_r       <= 1'b0;
            err_r        <= 1'b0;
        end else begin
            in_ready_r   <= (state_s == ST_LOAD);
            des_enable_r <= (state_s == ST_START);
            out_valid_r  <= (state_s == ST_DRAIN);
            busy_r       <= (state_s != ST_LOAD);
            err_r        <= timeout_s;
        end
    end

    assign in_ready        = in_ready_r;
    assign des_enable      = des_enable_r;
    assign des_encr_decr   = mode_r;
    assign des_input_block = in_shift_r;
    assign out_byte        = out_shift_r[63:56];
    assign out_valid       = out_valid_r;
    assign busy            = busy_r;
    assign err             = err_r;

endmodule

// File: tb/tb_tdes_byte_stream_adapter.sv
// Directed bench for tdes_byte_stream_adapter with the wait timeout set to 16.
// Inputs change and outputs are sampled on the falling clock edge.

module tb_tdes_byte_stream_adapter;

    logic        clk;
    logic        rst;
    logic [7:0]  in_byte;
    logic        in_valid;
    logic        in_ready;
    logic        in_mode;
    logic        des_enable;
    logic        des_encr_decr;
    logic [63:0] des_input_block;
    logic [63:0] des_output_block;
    logic        des_done;
    logic [7:0]  out_byte;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        err;

    int checks;
    int errors;
    int err_pulses;

    tdes_byte_stream_adapter #(.TIMEOUT_CYCLES(16)) dut (
        .clk              (clk),
        .rst              (rst),
        .in_byte          (in_byte),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_mode          (in_mode),
        .des_enable       (des_enable),
        .des_encr_decr    (des_encr_decr),
        .des_input_block  (des_input_block),
        .des_output_block (des_output_block),
        .des_done         (des_done),
        .out_byte         (out_byte),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .busy             (busy),
        .err              (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count err pulses seen at every falling edge.
    always @(negedge clk) begin
        if (err === 1'b1) err_pulses++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present the eight bytes of blk back to back; returns at the START cycle.
    task automatic load_block(input logic [63:0] blk, input logic mode);
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_byte  = blk[63 - 8*i -: 8];
            in_mode  = mode;
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_byte  = 8'h00;
    endtask

    // Expect the eight bytes of blk on consecutive cycles with out_ready high.
    task automatic drain_check(input string tag, input logic [63:0] blk);
        for (int j = 0; j < 8; j++) begin
            chk({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
            chk({tag, "_byte"}, {56'd0, out_byte}, {56'd0, blk[63 - 8*j -: 8]});
            @(negedge clk);
        end
        chk({tag, "_end_valid"}, {63'd0, out_valid}, 64'd0);
        chk({tag, "_end_ready"}, {63'd0, in_ready}, 64'd1);
    endtask

    initial begin
        logic [63:0] blk2;
        int          gaps [8];

        checks = 0; errors = 0; err_pulses = 0;
        rst = 1'b1; in_byte = 8'h00; in_valid = 1'b0; in_mode = 1'b0;
        des_output_block = 64'h0; des_done = 1'b0; out_ready = 1'b1;
        gaps = '{0, 2, 0, 1, 3, 0, 0, 1};
        blk2 = 64'hA1B2C3D4E5F60718;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_des_enable", {63'd0, des_enable}, 64'd0);
        chk("rst_encr_decr", {63'd0, des_encr_decr}, 64'd0);
        chk("rst_input_block", des_input_block, 64'h0);
        chk("rst_out_byte", {56'd0, out_byte}, 64'd0);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_err", {63'd0, err}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Block 1: continuous bytes, done five cycles after enable
        load_block(64'h0123456789ABCDEF, 1'b1);
        chk("b1_enable", {63'd0, des_enable}, 64'd1);
        chk("b1_in_ready", {63'd0, in_ready}, 64'd0);
        chk("b1_block", des_input_block, 64'h0123456789ABCDEF);
        chk("b1_mode", {63'd0, des_encr_decr}, 64'd1);
        chk("b1_busy", {63'd0, busy}, 64'd1);
        @(negedge clk);
        chk("b1_enable_once", {63'd0, des_enable}, 64'd0);
        repeat (4) @(negedge clk);
        des_done = 1'b1;
        des_output_block = 64'hFEDCBA9876543210;
        @(negedge clk);
        des_done = 1'b0;
        drain_check("b1_out", 64'hFEDCBA9876543210);
        chk("b1_idle_busy", {63'd0, busy}, 64'd0);

        // Block 2: input gaps, mode toggling after the first byte
        for (int i = 0; i < 8; i++) begin
            for (int g = 0; g < gaps[i]; g++) begin
                in_valid = 1'b0;
                in_byte  = 8'h5A;
                in_mode  = ~in_mode;
                @(negedge clk);
            end
            in_valid = 1'b1;
            in_byte  = blk2[63 - 8*i -: 8];
            in_mode  = (i == 0) ? 1'b0 : ~in_mode;
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("b2_enable", {63'd0, des_enable}, 64'd1);
        chk("b2_block", des_input_block, blk2);
        chk("b2_mode", {63'd0, des_encr_decr}, 64'd0);
        @(negedge clk);
        // Input ignored outside LOAD
        in_valid = 1'b1;
        in_byte  = 8'h99;
        @(negedge clk);
        in_valid = 1'b0;
        chk("b2_block_hold", des_input_block, blk2);
        des_done = 1'b1;
        des_output_block = 64'h1122334455667788;
        @(negedge clk);
        des_done = 1'b0;
        // Output backpressure mid-drain
        for (int j = 0; j < 3; j++) begin
            chk("b2_pre_byte", {56'd0, out_byte}, {56'd0, 8'h11 * (j + 1)});
            @(negedge clk);
        end
        out_ready = 1'b0;
        for (int s = 0; s < 10; s++) begin
            @(negedge clk);
            chk("b2_stall_byte", {56'd0, out_byte}, 64'h44);
            chk("b2_stall_valid", {63'd0, out_valid}, 64'd1);
        end
        out_ready = 1'b1;
        for (int j = 3; j < 8; j++) begin
            chk("b2_post_byte", {56'd0, out_byte}, {56'd0, 8'h11 * (j + 1)});
            @(negedge clk);
        end
        chk("b2_end_valid", {63'd0, out_valid}, 64'd0);
        chk("b2_end_ready", {63'd0, in_ready}, 64'd1);
        #1;
        chk("b2_no_err", err_pulses, 64'd0);

        // Spurious done while in LOAD
        des_done = 1'b1;
        des_output_block = 64'hDEADBEEFDEADBEEF;
        @(negedge clk);
        des_done = 1'b0;
        chk("spur_valid", {63'd0, out_valid}, 64'd0);
        chk("spur_busy", {63'd0, busy}, 64'd0);
        chk("spur_ready", {63'd0, in_ready}, 64'd1);

        // Block 3: done never arrives
        load_block(64'h0F1E2D3C4B5A6978, 1'b0);
        chk("b3_enable", {63'd0, des_enable}, 64'd1);
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            if (k == 16) begin
                chk("to_err_early", {63'd0, err}, 64'd0);
                chk("to_busy", {63'd0, busy}, 64'd1);
            end
            if (k == 17) begin
                chk("to_err", {63'd0, err}, 64'd1);
                chk("to_in_ready", {63'd0, in_ready}, 64'd1);
                chk("to_out_valid", {63'd0, out_valid}, 64'd0);
            end
        end
        @(negedge clk);
        chk("to_err_pulse", {63'd0, err}, 64'd0);

        // Block 4: done on the final timeout cycle
        load_block(64'h8899AABBCCDDEEFF, 1'b1);
        chk("b4_block", des_input_block, 64'h8899AABBCCDDEEFF);
        chk("b4_mode", {63'd0, des_encr_decr}, 64'd1);
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
        end
        des_done = 1'b1;
        des_output_block = 64'h0011223344556677;
        @(negedge clk);
        des_done = 1'b0;
        chk("b4_err", {63'd0, err}, 64'd0);
        drain_check("b4_out", 64'h0011223344556677);
        #1;
        chk("b4_err_total", err_pulses, 64'd1);

        // Block 5: reset after three output bytes
        load_block(64'h13579BDF2468ACE0, 1'b1);
        @(negedge clk);
        des_done = 1'b1;
        des_output_block = 64'hC0FFEE5512345678;
        @(negedge clk);
        des_done = 1'b0;
        for (int j = 0; j < 3; j++) @(negedge clk);
        chk("b5_pre_byte", {56'd0, out_byte}, 64'h55);
        #2;
        rst = 1'b1;
        #1;
        chk("b5_rst_valid", {63'd0, out_valid}, 64'd0);
        chk("b5_rst_byte", {56'd0, out_byte}, 64'd0);
        chk("b5_rst_busy", {63'd0, busy}, 64'd0);
        chk("b5_rst_ready", {63'd0, in_ready}, 64'd1);
        chk("b5_rst_block", des_input_block, 64'h0);
        chk("b5_rst_mode", {63'd0, des_encr_decr}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Block 6: normal operation after reset
        load_block(64'h2468ACE013579BDF, 1'b0);
        chk("b6_enable", {63'd0, des_enable}, 64'd1);
        chk("b6_block", des_input_block, 64'h2468ACE013579BDF);
        @(negedge clk);
        des_done = 1'b1;
        des_output_block = 64'h55AA33CC0FF01234;
        @(negedge clk);
        des_done = 1'b0;
        drain_check("b6_out", 64'h55AA33CC0FF01234);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
